// File: rtl/snd_pkg.sv
// Shared types for the main/sound CPU command mailbox.
package snd_pkg;

  typedef enum logic {
    SNDMB_DROP,
    SNDMB_OVERWRITE
  } full_policy_t;

endpackage

// File: rtl/snd_fifo.sv
// Single-direction mailbox FIFO: register-array storage, registered head output,
// selectable drop/overwrite behaviour when pushed while full.
module snd_fifo
  import snd_pkg::*;
#(
  parameter int unsigned  WIDTH       = 8,
  parameter int unsigned  DEPTH       = 4,
  parameter full_policy_t FULL_POLICY = SNDMB_DROP
) (
  input  logic                       clk_sys,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf_set
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  wr_addr;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             do_pop, do_push, do_ovw, wr_en;

  // A single-entry FIFO keeps both pointers pinned at zero.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (DEPTH == 1) ? '0 : p + PtrW'(1);
  endfunction

  function automatic logic [PtrW-1:0] ptr_dec(input logic [PtrW-1:0] p);
    return (DEPTH == 1) ? '0 : p - PtrW'(1);
  endfunction

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = dout_q;

  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    do_ovw  = push && full && !do_pop && (FULL_POLICY == SNDMB_OVERWRITE);
    ovf_set = push && full && !do_pop;
    wr_en   = do_push || do_ovw;
    wr_addr = do_ovw ? ptr_dec(wptr_q) : wptr_q;
    rptr_d  = do_pop ? ptr_inc(rptr_q) : rptr_q;
    wptr_d  = do_push ? ptr_inc(wptr_q) : wptr_q;

    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CntW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CntW'(1);
    end

    // Head register tracks the next head; bypass covers a write landing on that slot.
    dout_d = dout_q;
    if (count_d != '0) begin
      dout_d = (wr_en && (wr_addr == rptr_d)) ? din : mem_q[rptr_d];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      dout_q  <= dout_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (wr_en) begin
      mem_q[wr_addr] <= din;
    end
  end

endmodule

// File: rtl/snd_mailbox.sv
// Bidirectional main/sound CPU mailbox: command FIFO towards the sound CPU, reply
// FIFO back to the main CPU, with sticky overflow flags and an active-low sound IRQ.
module snd_mailbox
  import snd_pkg::*;
#(
  parameter int unsigned  WIDTH       = 8,
  parameter int unsigned  M2S_DEPTH   = 4,
  parameter int unsigned  S2M_DEPTH   = 1,
  parameter full_policy_t FULL_POLICY = SNDMB_DROP
) (
  input  logic                           clk_sys,
  input  logic                           reset,
  input  logic                           main_wr,
  input  logic [WIDTH-1:0]               main_din,
  input  logic                           main_rd,
  output logic [WIDTH-1:0]               main_dout,
  output logic                           main_rdy,
  output logic                           main_full,
  input  logic                           snd_wr,
  input  logic [WIDTH-1:0]               snd_din,
  input  logic                           snd_ack,
  output logic [WIDTH-1:0]               snd_dout,
  output logic                           snd_irq_n,
  output logic                           snd_full,
  output logic [$clog2(M2S_DEPTH+1)-1:0] m2s_count,
  output logic [$clog2(S2M_DEPTH+1)-1:0] s2m_count,
  output logic [1:0]                     ovf,
  input  logic [1:0]                     ovf_clr
);

  logic       m2s_empty, s2m_empty;
  logic [1:0] ovf_set;
  logic [1:0] ovf_q, ovf_d;

  snd_fifo #(
    .WIDTH       (WIDTH),
    .DEPTH       (M2S_DEPTH),
    .FULL_POLICY (FULL_POLICY)
  ) u_m2s (
    .clk_sys (clk_sys),
    .reset   (reset),
    .push    (main_wr),
    .din     (main_din),
    .pop     (snd_ack),
    .dout    (snd_dout),
    .count   (m2s_count),
    .full    (main_full),
    .empty   (m2s_empty),
    .ovf_set (ovf_set[0])
  );

  snd_fifo #(
    .WIDTH       (WIDTH),
    .DEPTH       (S2M_DEPTH),
    .FULL_POLICY (FULL_POLICY)
  ) u_s2m (
    .clk_sys (clk_sys),
    .reset   (reset),
    .push    (snd_wr),
    .din     (snd_din),
    .pop     (main_rd),
    .dout    (main_dout),
    .count   (s2m_count),
    .full    (snd_full),
    .empty   (s2m_empty),
    .ovf_set (ovf_set[1])
  );

  // Set has priority over a same-cycle clear.
  always_comb begin
    ovf_d = (ovf_q & ~ovf_clr) | ovf_set;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf       = ovf_q;
  assign snd_irq_n = m2s_empty;
  assign main_rdy  = !s2m_empty;

endmodule

// File: tb/tb_snd_mailbox.sv
// Directed bench for snd_mailbox: a DROP and an OVERWRITE instance share stimulus and
// are checked every cycle against a queue-based model, plus literal spot checks.
module tb_snd_mailbox;
  import snd_pkg::*;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       main_wr, main_rd, snd_wr, snd_ack;
  logic [7:0] main_din, snd_din;
  logic [1:0] ovf_clr;

  logic [7:0] d0_main_dout, d0_snd_dout, d1_main_dout, d1_snd_dout;
  logic       d0_main_rdy, d0_main_full, d0_snd_irq_n, d0_snd_full;
  logic       d1_main_rdy, d1_main_full, d1_snd_irq_n, d1_snd_full;
  logic [2:0] d0_m2s_count, d1_m2s_count;
  logic [0:0] d0_s2m_count, d1_s2m_count;
  logic [1:0] d0_ovf, d1_ovf;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_sys = ~clk_sys;

  snd_mailbox #(
    .WIDTH(8), .M2S_DEPTH(4), .S2M_DEPTH(1), .FULL_POLICY(SNDMB_DROP)
  ) dut0 (
    .clk_sys(clk_sys), .reset(reset),
    .main_wr(main_wr), .main_din(main_din), .main_rd(main_rd),
    .main_dout(d0_main_dout), .main_rdy(d0_main_rdy), .main_full(d0_main_full),
    .snd_wr(snd_wr), .snd_din(snd_din), .snd_ack(snd_ack),
    .snd_dout(d0_snd_dout), .snd_irq_n(d0_snd_irq_n), .snd_full(d0_snd_full),
    .m2s_count(d0_m2s_count), .s2m_count(d0_s2m_count), .ovf(d0_ovf), .ovf_clr(ovf_clr)
  );

  snd_mailbox #(
    .WIDTH(8), .M2S_DEPTH(4), .S2M_DEPTH(1), .FULL_POLICY(SNDMB_OVERWRITE)
  ) dut1 (
    .clk_sys(clk_sys), .reset(reset),
    .main_wr(main_wr), .main_din(main_din), .main_rd(main_rd),
    .main_dout(d1_main_dout), .main_rdy(d1_main_rdy), .main_full(d1_main_full),
    .snd_wr(snd_wr), .snd_din(snd_din), .snd_ack(snd_ack),
    .snd_dout(d1_snd_dout), .snd_irq_n(d1_snd_irq_n), .snd_full(d1_snd_full),
    .m2s_count(d1_m2s_count), .s2m_count(d1_s2m_count), .ovf(d1_ovf), .ovf_clr(ovf_clr)
  );

  // Model: index = dut*2 + dir (dir 0 = main->sound, 1 = sound->main).
  logic [7:0] mq [4][$];
  logic [7:0] mdout [4];
  logic [1:0] movf [2];
  bit         mvalid = 0;

  task automatic model_step();
    int d, k, depth;
    bit ps, pp, set;
    logic [7:0] din;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        mq[i].delete();
        mdout[i] = 8'h00;
      end
      movf[0] = 2'b00;
      movf[1] = 2'b00;
      mvalid = 1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        d     = i / 2;
        k     = i % 2;
        ps    = (k == 0) ? main_wr : snd_wr;
        pp    = (k == 0) ? snd_ack : main_rd;
        din   = (k == 0) ? main_din : snd_din;
        depth = (k == 0) ? 4 : 1;
        set   = 0;
        if (pp && mq[i].size() > 0) begin
          void'(mq[i].pop_front());
          if (ps) mq[i].push_back(din);
        end else if (ps) begin
          if (mq[i].size() < depth) mq[i].push_back(din);
          else begin
            set = 1;
            if (d == 1) mq[i][mq[i].size()-1] = din;
          end
        end
        if (mq[i].size() > 0) mdout[i] = mq[i][0];
        movf[d][k] = set | (movf[d][k] & ~ovf_clr[k]);
      end
    end
  endtask

  initial forever begin
    @(posedge clk_sys);
    model_step();
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(input int d, input logic [7:0] mdo, input logic [7:0] sdo,
                           input logic rdy, input logic irq, input logic mf, input logic sf,
                           input logic [2:0] mc, input logic sc, input logic [1:0] ov);
    int im, is;
    im = d * 2;
    is = d * 2 + 1;
    chk($sformatf("d%0d_snd_dout", d), 32'(sdo), 32'(mdout[im]));
    chk($sformatf("d%0d_main_dout", d), 32'(mdo), 32'(mdout[is]));
    chk($sformatf("d%0d_m2s_count", d), 32'(mc), 32'(mq[im].size()));
    chk($sformatf("d%0d_s2m_count", d), 32'(sc), 32'(mq[is].size()));
    chk($sformatf("d%0d_snd_irq_n", d), 32'(irq), 32'(mq[im].size() == 0));
    chk($sformatf("d%0d_main_rdy", d), 32'(rdy), 32'(mq[is].size() != 0));
    chk($sformatf("d%0d_main_full", d), 32'(mf), 32'(mq[im].size() == 4));
    chk($sformatf("d%0d_snd_full", d), 32'(sf), 32'(mq[is].size() == 1));
    chk($sformatf("d%0d_ovf", d), 32'(ov), 32'(movf[d]));
  endtask

  initial forever begin
    @(negedge clk_sys);
    if (mvalid) begin
      check_dut(0, d0_main_dout, d0_snd_dout, d0_main_rdy, d0_snd_irq_n, d0_main_full,
                d0_snd_full, d0_m2s_count, d0_s2m_count[0], d0_ovf);
      check_dut(1, d1_main_dout, d1_snd_dout, d1_main_rdy, d1_snd_irq_n, d1_main_full,
                d1_snd_full, d1_m2s_count, d1_s2m_count[0], d1_ovf);
    end
  end

  // Apply one cycle of inputs; returns at the following negedge.
  task automatic step(input logic mw, input logic [7:0] md, input logic mr, input logic sw,
                      input logic [7:0] sd, input logic sa, input logic [1:0] clr,
                      input logic rst);
    main_wr  = mw;
    main_din = md;
    main_rd  = mr;
    snd_wr   = sw;
    snd_din  = sd;
    snd_ack  = sa;
    ovf_clr  = clr;
    reset    = rst;
    @(negedge clk_sys);
  endtask

  task automatic idle();
    step(0, 8'h00, 0, 0, 8'h00, 0, 2'b00, 0);
  endtask

  task automatic mpush(input logic [7:0] v);
    step(1, v, 0, 0, 8'h00, 0, 2'b00, 0);
  endtask

  task automatic sack();
    step(0, 8'h00, 0, 0, 8'h00, 1, 2'b00, 0);
  endtask

  initial begin
    step(0, 8'h00, 0, 0, 8'h00, 0, 2'b00, 1);
    step(0, 8'h00, 0, 0, 8'h00, 0, 2'b00, 1);
    idle();
    chk("reset_irq_n", 32'(d0_snd_irq_n), 32'd1);
    chk("reset_main_dout", 32'(d0_main_dout), 32'h00);
    chk("reset_m2s_count", 32'(d0_m2s_count), 32'd0);
    chk("reset_ovf", 32'(d1_ovf), 32'd0);

    mpush(8'h11);
    chk("first_push_dout", 32'(d0_snd_dout), 32'h11);
    chk("first_push_irq", 32'(d0_snd_irq_n), 32'd0);
    mpush(8'h22);
    mpush(8'h33);
    chk("three_push_count", 32'(d0_m2s_count), 32'd3);
    chk("three_push_head", 32'(d0_snd_dout), 32'h11);
    sack();
    chk("ack1_dout", 32'(d0_snd_dout), 32'h22);
    sack();
    chk("ack2_dout", 32'(d0_snd_dout), 32'h33);
    sack();
    chk("ack3_count", 32'(d0_m2s_count), 32'd0);
    chk("ack3_irq", 32'(d0_snd_irq_n), 32'd1);
    chk("ack3_hold", 32'(d0_snd_dout), 32'h33);

    for (int v = 1; v <= 5; v++) mpush(8'(v));
    chk("drop_count", 32'(d0_m2s_count), 32'd4);
    chk("drop_ovf", 32'(d0_ovf), 32'b01);
    chk("drop_full", 32'(d0_main_full), 32'd1);
    chk("drop_head", 32'(d0_snd_dout), 32'h01);
    for (int v = 2; v <= 4; v++) begin
      sack();
      chk("drop_order", 32'(d0_snd_dout), 32'(v));
    end
    sack();
    chk("drop_drained", 32'(d0_m2s_count), 32'd0);
    step(0, 8'h00, 0, 0, 8'h00, 0, 2'b01, 0);
    chk("ovf_clr0", 32'(d0_ovf), 32'd0);

    step(0, 8'h00, 0, 1, 8'hA5, 0, 2'b00, 0);
    step(0, 8'h00, 0, 1, 8'h5A, 0, 2'b00, 0);
    chk("ow_main_dout", 32'(d1_main_dout), 32'h5A);
    chk("ow_ovf", 32'(d1_ovf), 32'b10);
    chk("ow_rdy", 32'(d1_main_rdy), 32'd1);
    chk("drop_s2m_dout", 32'(d0_main_dout), 32'hA5);
    step(0, 8'h00, 1, 0, 8'h00, 0, 2'b00, 0);
    chk("s2m_pop_rdy", 32'(d0_main_rdy), 32'd0);
    step(0, 8'h00, 1, 0, 8'h00, 0, 2'b10, 0);
    chk("ovf_clr1", 32'(d1_ovf), 32'd0);

    for (int v = 8'h41; v <= 8'h44; v++) mpush(8'(v));
    step(1, 8'h45, 0, 0, 8'h00, 1, 2'b00, 0);
    chk("full_pp_count", 32'(d0_m2s_count), 32'd4);
    chk("full_pp_ovf", 32'(d0_ovf), 32'd0);
    chk("full_pp_head", 32'(d0_snd_dout), 32'h42);
    for (int v = 8'h43; v <= 8'h45; v++) begin
      sack();
      chk("full_pp_order", 32'(d0_snd_dout), 32'(v));
    end
    sack();

    step(1, 8'h66, 0, 0, 8'h00, 1, 2'b00, 0);
    chk("empty_pp_count", 32'(d0_m2s_count), 32'd1);
    chk("empty_pp_dout", 32'(d0_snd_dout), 32'h66);
    sack();

    mpush(8'h01);
    mpush(8'h02);
    mpush(8'h03);
    step(0, 8'h00, 0, 0, 8'h00, 0, 2'b00, 1);
    chk("midrst_count", 32'(d0_m2s_count), 32'd0);
    chk("midrst_irq", 32'(d0_snd_irq_n), 32'd1);
    mpush(8'h77);
    chk("post_rst_dout", 32'(d0_snd_dout), 32'h77);
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
